alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Sequential responder for the ALU operation interface. It accepts (f, a, b) requests over a valid/ready handshake and returns (y, zero) responses over a second valid/ready handshake.
- Two-stage pipeline wrapped around a combinational ALU core. Sustains one operation per cycle when the sink does not stall.
- Sits between a vector/instruction sequencer and result-checking or writeback logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- TAG_W, 4, width of the opaque request tag that passes through to the response.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_f  input  3  ALU function code.
- req_a  input  WIDTH  operand a.
- req_b  input  WIDTH  operand b.
- req_tag  input  TAG_W  request tag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  sink accepts the response.
- rsp_y  output  WIDTH  result.
- rsp_zero  output  1  high when rsp_y == 0.
- rsp_tag  output  TAG_W  tag of the request that produced this response.
- op_count  output  16  number of completed response handshakes; wraps modulo 2^16.

Behaviour:
- Function codes:
  - 000: a & b
  - 001: a | b
  - 010: a + b
  - 011: reserved, y = 0
  - 100: a & ~b
  - 101: a | ~b
  - 110: a - b
  - 111: SLT, y = 1 if signed(a) < signed(b), else 0; y is zero-extended to WIDTH.
- Arithmetic is modulo 2^WIDTH. The carry-out is discarded.
- Stage S1 (operand register): holds f, a, b, tag and valid bit v1.
- Stage S2 (result register): holds y, zero, tag and valid bit v2. y and zero are computed from S1 by the core.
- Transfers:
  - req_fire = req_valid & req_ready.
  - rsp_fire = rsp_valid & rsp_ready.
  - rsp_valid = v2.
  - S2 advances when !v2 | rsp_ready.
  - S1 advances into S2 when v1 and S2 advances.
  - req_ready = !v1 | (S2 advances). req_ready is combinational from rsp_ready; there is no combinational path from req_valid.
- Latency: a request accepted on edge N is presented as rsp_valid after edge N+1, i.e. two edges from acceptance to visibility. The first response appears one cycle after the cycle in which the request was accepted.
- Throughput: with rsp_ready held high, back-to-back requests produce back-to-back responses, one per cycle.
- Stall: with rsp_ready low, the S2 payload stays stable and rsp_valid stays high. S1 fills, then req_ready drops. No request is lost or duplicated.
- Simultaneous events:
  - rsp_fire and req_fire in the same cycle with the pipe full: S2 takes S1 and S1 takes the new request.
  - Empty pipe: S2 is bypassed by nothing. Every response takes the full two-stage latency.
- op_count increments by 1 on each rsp_fire and wraps from 0xFFFF to 0.
- Reset, asynchronous, at any time including mid-operation:
  - v1 = v2 = 0, so rsp_valid = 0.
  - All data registers = 0, so rsp_y = 0, rsp_zero = 0 and rsp_tag = 0.
  - op_count = 0.
  - req_ready = 1 immediately after reset asserts.
  - In-flight operations are dropped and no response is issued for them.

Optional Feature:
- ALU_OVF_EN defined:
  - Adds output port rsp_ovf (1 bit), registered in S2 alongside y.
  - Signed overflow for 010: operand signs equal and result sign differs from them.
  - Signed overflow for 110: operand signs differ and result sign differs from a.
  - rsp_ovf = 0 for all other codes. It resets to 0.
- ALU_OVF_EN undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - function-code constants ALU_AND, ALU_OR, ALU_ADD, ALU_RSVD, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT
  - default WIDTH
  - response struct/typedef {y, zero, tag}
- Sub-module alu_core: purely combinational (f, a, b) -> (y, zero[, ovf]). It is instantiated between S1 and S2. All pipeline and handshake logic stays in alu_pipe.

Test Plan:
- Reset, then one request f=010, a=2, b=3, tag=5, rsp_ready=1 -> one cycle after acceptance rsp_valid=1, y=5, zero=0, tag=5; op_count=1 after the handshake.
- f=110, a=7, b=7 -> y=0, zero=1. Then f=111, a=0xFFFFFFFF, b=1 -> y=1 (signed -1 < 1). Then f=111, a=1, b=0xFFFFFFFF -> y=0.
- Stream 21 back-to-back requests with rsp_ready=1 -> 21 consecutive rsp_valid cycles with no gaps, responses in order with matching tags, op_count=21.
- Hold rsp_ready=0 and offer 4 requests -> exactly 2 accepted, req_ready=0 after that, S2 payload stable. Release rsp_ready -> the remaining requests drain in order with none lost or duplicated.
- Assert reset_n=0 mid-stream with the pipe full -> rsp_valid, rsp_y and op_count drop to 0 asynchronously. After release, the next request yields the correct first response with no stale data.
- ALU_OVF_EN defined: f=010, a=0x7FFFFFFF, b=1 -> y=0x80000000, ovf=1. f=110, a=0x80000000, b=1 -> ovf=1. f=000 with any operands -> ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, default widths and response type.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_TAG_W = 4;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_RSVD = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_fn_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] y;
        logic                 zero;
        logic [ALU_TAG_W-1:0] tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU core; o_ovf exists only when ALU_OVF_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       i_f,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_zero
`ifdef ALU_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_lt   = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_y = '0;
        case (alu_fn_e'(i_f))
            ALU_AND:  o_y = i_a & i_b;
            ALU_OR:   o_y = i_a | i_b;
            ALU_ADD:  o_y = w_sum;
            ALU_RSVD: o_y = '0;
            ALU_ANDN: o_y = i_a & ~i_b;
            ALU_ORN:  o_y = i_a | ~i_b;
            ALU_SUB:  o_y = w_diff;
            ALU_SLT:  o_y = {{(WIDTH-1){1'b0}}, w_lt};
            default:  o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);

`ifdef ALU_OVF_EN
    // Signed overflow is judged on the sign bits of the operands and the wrapped result.
    always_comb begin
        o_ovf = 1'b0;
        case (alu_fn_e'(i_f))
            ALU_ADD: o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            ALU_SUB: o_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            default: o_ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready pipeline around alu_core.
// Optional rsp_ovf output is present when ALU_OVF_EN is defined.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_f,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      op_count
`ifdef ALU_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    logic             r_v1;
    logic [2:0]       r_f1;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic [TAG_W-1:0] r_tag1;

    logic             r_v2;
    logic [WIDTH-1:0] r_y2;
    logic             r_zero2;
    logic [TAG_W-1:0] r_tag2;
    logic [15:0]      r_op_count;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_req_fire;
    logic             w_rsp_fire;
    logic [WIDTH-1:0] w_y;
    logic             w_zero;

    // Ready depends only on state and rsp_ready, never on req_valid.
    assign w_s2_adv   = !r_v2 || rsp_ready;
    assign w_s1_adv   = r_v1 && w_s2_adv;
    assign req_ready  = !r_v1 || w_s2_adv;
    assign w_req_fire = req_valid && req_ready;
    assign w_rsp_fire = r_v2 && rsp_ready;

`ifdef ALU_OVF_EN
    logic w_ovf;
    logic r_ovf2;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_f    (r_f1),
        .i_a    (r_a1),
        .i_b    (r_b1),
        .o_y    (w_y),
        .o_zero (w_zero),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf2 <= 1'b0;
        end else if (w_s1_adv) begin
            r_ovf2 <= w_ovf;
        end
    end

    assign rsp_ovf = r_ovf2;
`else
    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_f    (r_f1),
        .i_a    (r_a1),
        .i_b    (r_b1),
        .o_y    (w_y),
        .o_zero (w_zero)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1   <= 1'b0;
            r_f1   <= '0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_tag1 <= '0;
        end else if (w_req_fire) begin
            r_v1   <= 1'b1;
            r_f1   <= req_f;
            r_a1   <= req_a;
            r_b1   <= req_b;
            r_tag1 <= req_tag;
        end else if (w_s1_adv) begin
            r_v1   <= 1'b0;
        end
    end

    // S2 keeps its last payload when it drains empty; only v2 matters then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v2    <= 1'b0;
            r_y2    <= '0;
            r_zero2 <= 1'b0;
            r_tag2  <= '0;
        end else if (w_s2_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_y2    <= w_y;
                r_zero2 <= w_zero;
                r_tag2  <= r_tag1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count <= '0;
        end else if (w_rsp_fire) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign rsp_valid = r_v2;
    assign rsp_y     = r_y2;
    assign rsp_zero  = r_zero2;
    assign rsp_tag   = r_tag2;
    assign op_count  = r_op_count;

endmodule
